gf180_ram_banked: RTL and testbench

GF180_RAM_BANKED -- requirements
Module: gf180_ram_banked

---
 rtl/gf180_ram_banked.sv | 144 ++++++++++++++
 tb/tb_gf180_ram_banked.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/gf180_ram_banked.sv
// Banked 32-bit SRAM built from 512x8 GF180 macros.
// Read data 1 cycle after accept (2 with OUT_REG); a held response stalls all new requests.
module gf180_ram_banked #(
    parameter int NBANKS  = 2,
    parameter int OUT_REG = 0,
    localparam int AW     = 9 + $clog2(NBANKS),
    localparam int BW     = (NBANKS > 1) ? $clog2(NBANKS) : 1
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic          req_valid,
    output logic          req_ready,
    input  logic          req_we,
    input  logic [3:0]    req_be,
    input  logic [AW-1:0] req_addr,
    input  logic [31:0]   req_wdata,
    output logic          rsp_valid,
    input  logic          rsp_ready,
    output logic [31:0]   rsp_rdata,
    inout  wire           VDD,
    inout  wire           VSS
);

    logic          accept;
    logic          rd_accept;
    logic          mem_en;
    logic          gwen;
    logic          stall;
    logic          s1_vld;
    logic          rsp_vld_q;
    logic [31:0]   rsp_dat;
    logic [31:0]   rd_q;
    logic [BW-1:0] bank_sel;
    logic [BW-1:0] rd_bank_q;
    logic [31:0]   bank_q [NBANKS];

    assign stall     = rsp_valid & ~rsp_ready;
    assign req_ready = ~stall & ~RST;
    assign accept    = req_valid & req_ready;
    assign rd_accept = accept & ~req_we;
    // A write with no byte enabled is accepted but never touches a macro.
    assign mem_en    = accept & (~req_we | (|req_be));
    assign gwen      = ~(accept & req_we);

    if (NBANKS > 1) begin : g_dec
        assign bank_sel = req_addr[AW-1:9];
    end else begin : g_dec_one
        assign bank_sel = 1'b0;
    end

    for (genvar b = 0; b < NBANKS; b++) begin : g_bank
        logic        cen;
        logic [31:0] q;
        assign cen       = ~(mem_en && (bank_sel == BW'(b)));
        assign bank_q[b] = q;
        for (genvar n = 0; n < 4; n++) begin : g_lane
            logic [7:0] wen;
            assign wen = req_we ? {8{~req_be[n]}} : 8'hFF;
            gf180mcu_fd_ip_sram__sram512x8m8wm1 u_sram (
                .CLK  (CLK),
                .CEN  (cen),
                .GWEN (gwen),
                .WEN  (wen),
                .A    (req_addr[8:0]),
                .D    (req_wdata[8*n +: 8]),
                .Q    (q[8*n +: 8]),
                .VDD  (VDD),
                .VSS  (VSS)
            );
        end
    end

    // Q is selected by the bank captured at accept; the live address may already point elsewhere.
    always_comb begin
        rd_q = 32'h0;
        for (int b = 0; b < NBANKS; b++) begin
            if (rd_bank_q == BW'(b)) rd_q = bank_q[b];
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            s1_vld    <= 1'b0;
            rd_bank_q <= '0;
        end else if (!stall) begin
            s1_vld <= rd_accept;
            if (rd_accept) rd_bank_q <= bank_sel;
        end
    end

    if (OUT_REG != 0) begin : g_oreg
        logic        s2_vld;
        logic [31:0] s2_dat;
        always_ff @(posedge CLK) begin
            if (RST) begin
                s2_vld <= 1'b0;
                s2_dat <= 32'h0;
            end else if (!stall) begin
                s2_vld <= s1_vld;
                s2_dat <= rd_q;
            end
        end
        assign rsp_vld_q = s2_vld;
        assign rsp_dat   = s2_dat;
    end else begin : g_comb
        assign rsp_vld_q = s1_vld;
        assign rsp_dat   = rd_q;
    end

    assign rsp_valid = rsp_vld_q & ~RST;
    assign rsp_rdata = rsp_valid ? rsp_dat : 32'h0;

endmodule

// Behavioural model of the 512x8 GF180 SRAM macro: active-low CEN/GWEN/WEN, Q holds the last read.
// Single-cycle access on the rising edge; no flow control.
module gf180mcu_fd_ip_sram__sram512x8m8wm1 (
    input  logic       CLK,
    input  logic       CEN,
    input  logic       GWEN,
    input  logic [7:0] WEN,
    input  logic [8:0] A,
    input  logic [7:0] D,
    output logic [7:0] Q,
    inout  wire        VDD,
    inout  wire        VSS
);

    logic [7:0] mem [512];
    wire        unused_pwr = VDD ^ VSS;

    always_ff @(posedge CLK) begin
        if (!CEN) begin
            if (GWEN) begin
                Q <= mem[A];
            end else begin
                for (int i = 0; i < 8; i++) begin
                    if (!WEN[i]) mem[A][i] <= D[i];
                end
            end
        end
    end

endmodule

// File: tb/tb_gf180_ram_banked.sv
// Two instances (NBANKS=2/OUT_REG=0 and NBANKS=4/OUT_REG=1) checked every cycle against a word-array model.
module tb_gf180_ram_banked;

    logic        CLK = 1'b0;
    logic        RST;
    logic        req_valid [2];
    logic        req_ready [2];
    logic        req_we    [2];
    logic [3:0]  req_be    [2];
    logic [10:0] req_addr  [2];
    logic [31:0] req_wdata [2];
    logic        rsp_valid [2];
    logic        rsp_ready [2];
    logic [31:0] rsp_rdata [2];
    wire         vdd = 1'b1;
    wire         vss = 1'b0;
    wire  [7:0]  cen0;
    wire  [15:0] cen1;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    // Reference model: flat word memory plus ordered list of expected read responses.
    logic [31:0] mem  [2][2048];
    logic [31:0] fdat [2][64];
    int          facc [2][64];
    int          wp [2];
    int          rp [2];
    int          last_cons [2];
    int          hold [2];
    logic        rr_rand [2];
    logic        tmo [2];
    logic        done = 1'b0;
    logic        final_done = 1'b0;

    always #5 CLK = ~CLK;
    always @(posedge CLK) cyc <= cyc + 1;

    gf180_ram_banked #(.NBANKS(2), .OUT_REG(0)) dut0 (
        .CLK(CLK), .RST(RST),
        .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_we(req_we[0]),
        .req_be(req_be[0]), .req_addr(req_addr[0][9:0]), .req_wdata(req_wdata[0]),
        .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]), .rsp_rdata(rsp_rdata[0]),
        .VDD(vdd), .VSS(vss)
    );

    gf180_ram_banked #(.NBANKS(4), .OUT_REG(1)) dut1 (
        .CLK(CLK), .RST(RST),
        .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_we(req_we[1]),
        .req_be(req_be[1]), .req_addr(req_addr[1]), .req_wdata(req_wdata[1]),
        .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]), .rsp_rdata(rsp_rdata[1]),
        .VDD(vdd), .VSS(vss)
    );

    for (genvar b = 0; b < 2; b++) begin : g_c0
        for (genvar n = 0; n < 4; n++) begin : g_l
            assign cen0[b*4+n] = dut0.g_bank[b].g_lane[n].u_sram.CEN;
        end
    end
    for (genvar b = 0; b < 4; b++) begin : g_c1
        for (genvar n = 0; n < 4; n++) begin : g_l
            assign cen1[b*4+n] = dut1.g_bank[b].g_lane[n].u_sram.CEN;
        end
    end

    task automatic chk(input int d, input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL dut%0d %s: got %h, expected %h (cycle %0d)", d, tag, got, exp, cyc);
        end
    endtask

    always @(negedge CLK) begin
        logic [15:0] cen_now, cen_exp;
        logic [31:0] w, exp_dat;
        logic [10:0] a;
        logic        exp_vld, acc, en;
        int          lat, t, bank;
        for (int d = 0; d < 2; d++) begin
            cen_now = (d == 0) ? {8'hFF, cen0} : cen1;
            lat     = (d == 0) ? 1 : 2;
            if (RST) begin
                chk(d, "rst_req_ready", {31'h0, req_ready[d]}, 32'h0);
                chk(d, "rst_rsp_valid", {31'h0, rsp_valid[d]}, 32'h0);
                chk(d, "rst_rsp_rdata", rsp_rdata[d], 32'h0);
                chk(d, "rst_cen", {16'h0, cen_now}, 32'h0000FFFF);
                rp[d]        = wp[d];
                last_cons[d] = -100;
            end else begin
                exp_vld = 1'b0;
                exp_dat = 32'h0;
                if (wp[d] != rp[d]) begin
                    t = facc[d][rp[d] % 64] + lat;
                    if (last_cons[d] + 1 > t) t = last_cons[d] + 1;
                    if (cyc >= t) begin
                        exp_vld = 1'b1;
                        exp_dat = fdat[d][rp[d] % 64];
                    end
                end
                chk(d, "rsp_valid", {31'h0, rsp_valid[d]}, {31'h0, exp_vld});
                chk(d, "rsp_rdata", rsp_rdata[d], exp_dat);
                chk(d, "req_ready", {31'h0, req_ready[d]}, {31'h0, !(exp_vld && !rsp_ready[d])});

                a    = (d == 0) ? (req_addr[d] & 11'h3FF) : req_addr[d];
                bank = int'(a >> 9);
                acc  = req_valid[d] && req_ready[d];
                en   = acc && (!req_we[d] || req_be[d] != 4'h0);
                cen_exp = 16'hFFFF;
                if (en) cen_exp[bank*4 +: 4] = 4'h0;
                chk(d, "cen", {16'h0, cen_now}, {16'h0, cen_exp});

                if (exp_vld && rsp_ready[d]) begin
                    rp[d]++;
                    last_cons[d] = cyc;
                end
                if (acc) begin
                    if (req_we[d]) begin
                        w = mem[d][a];
                        for (int n = 0; n < 4; n++)
                            if (req_be[d][n]) w[8*n +: 8] = req_wdata[d][8*n +: 8];
                        mem[d][a] = w;
                    end else begin
                        fdat[d][wp[d] % 64] = mem[d][a];
                        facc[d][wp[d] % 64] = cyc;
                        wp[d]++;
                    end
                end
            end
            if (done && !final_done) begin
                chk(d, "rsp_outstanding", 32'(wp[d] - rp[d]), 32'h0);
                chk(d, "handshake_timeout", {31'h0, tmo[d]}, 32'h0);
            end
        end
        if (done) final_done = 1'b1;
    end

    task automatic step(input int d);
        @(posedge CLK);
        #1;
        if (hold[d] > 0) begin
            hold[d]--;
            rsp_ready[d] = 1'b0;
        end else begin
            rsp_ready[d] = rr_rand[d] ? ($urandom_range(0, 3) != 0) : 1'b1;
        end
    endtask

    task automatic do_req(input int d, input logic we, input logic [3:0] be,
                          input logic [10:0] a, input logic [31:0] wd);
        int   n;
        logic rdy;
        req_valid[d] = 1'b1;
        req_we[d]    = we;
        req_be[d]    = be;
        req_addr[d]  = a;
        req_wdata[d] = wd;
        n = 0;
        do begin
            @(negedge CLK);
            rdy = req_ready[d];
            step(d);
            n++;
        end while (!rdy && n < 200);
        if (!rdy) tmo[d] = 1'b1;
    endtask

    task automatic idle(input int d, input int n);
        req_valid[d] = 1'b0;
        repeat (n) step(d);
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "global timeout");
    end

    initial begin
        logic [10:0] a, prev_a;
        logic        we;
        logic [3:0]  be;
        int          words;
        for (int d = 0; d < 2; d++) begin
            req_valid[d] = 1'b0; req_we[d] = 1'b0; req_be[d] = 4'h0;
            req_addr[d]  = '0;   req_wdata[d] = '0; rsp_ready[d] = 1'b1;
            wp[d] = 0; rp[d] = 0; last_cons[d] = -100; hold[d] = 0;
            rr_rand[d] = 1'b0; tmo[d] = 1'b0;
        end
        RST = 1'b1;
        repeat (3) @(posedge CLK);
        #1 RST = 1'b0;

        for (int d = 0; d < 2; d++) begin
            idle(d, 2);
            do_req(d, 1'b1, 4'hF, 11'h005, 32'hDEADBEEF);
            do_req(d, 1'b1, 4'hF, 11'h205, 32'h12345678);
            do_req(d, 1'b0, 4'hF, 11'h005, 32'h0);
            do_req(d, 1'b0, 4'hF, 11'h205, 32'h0);
            idle(d, 2);
            do_req(d, 1'b1, 4'hF, 11'h003, 32'hFFFFFFFF);
            do_req(d, 1'b1, 4'b0100, 11'h003, 32'h00AA0000);
            do_req(d, 1'b0, 4'hF, 11'h003, 32'h0);
            idle(d, 3);
        end

        for (int d = 0; d < 2; d++) begin
            words = (d == 0) ? 1024 : 2048;
            for (int i = 0; i < words; i++) do_req(d, 1'b1, 4'hF, 11'(i), $urandom);
            idle(d, 2);
        end

        do_req(1, 1'b0, 4'hF, 11'h600, 32'h0);
        idle(1, 3);
        do_req(1, 1'b1, 4'h0, 11'h600, $urandom);
        idle(1, 3);

        for (int d = 0; d < 2; d++) begin
            rsp_ready[d] = 1'b0;
            hold[d] = 5;
            do_req(d, 1'b0, 4'hF, 11'h001, 32'h0);
            do_req(d, 1'b0, 4'hF, 11'h002, 32'h0);
            do_req(d, 1'b0, 4'hF, 11'h003, 32'h0);
            idle(d, 8);
        end

        for (int d = 0; d < 2; d++) begin
            a = 11'($urandom_range(0, (d == 0) ? 1023 : 2047));
            do_req(d, 1'b0, 4'hF, a, 32'h0);
            RST = 1'b1;
            idle(d, 2);
            RST = 1'b0;
            idle(d, 1);
            do_req(d, 1'b0, 4'hF, a, 32'h0);
            idle(d, 3);
        end

        for (int d = 0; d < 2; d++) begin
            for (int i = 0; i < 64; i++)
                do_req(d, 1'b0, 4'hF, 11'($urandom_range(0, (d == 0) ? 1023 : 2047)), 32'h0);
            idle(d, 4);
        end

        for (int d = 0; d < 2; d++) begin
            rr_rand[d] = 1'b1;
            prev_a = '0;
            for (int i = 0; i < 300; i++) begin
                if ($urandom_range(0, 4) == 0) idle(d, 1);
                we = 1'($urandom);
                be = ($urandom_range(0, 5) == 0) ? 4'h0 : 4'($urandom);
                a  = 11'($urandom_range(0, (d == 0) ? 1023 : 2047));
                if (!we && $urandom_range(0, 2) == 0) a = prev_a;
                do_req(d, we, be, a, $urandom);
                prev_a = a;
            end
            rr_rand[d] = 1'b0;
            idle(d, 6);
        end

        for (int i = 0; i < 50 && (wp[0] != rp[0] || wp[1] != rp[1]); i++) begin
            idle(0, 1);
            idle(1, 1);
        end
        done = 1'b1;
        repeat (2) @(negedge CLK);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
